// File: rtl/mux_rr_scheduler_pkg.sv
// mux_rr_scheduler_pkg: shared state encoding and sizes for the round-robin mux scheduler
package mux_rr_scheduler_pkg;
    localparam int NREQ  = 4;
    localparam int SEL_W = 2;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;
endpackage

// File: rtl/mux_rr_scheduler_if.sv
// mux_rr_scheduler_if: request/grant and datapath bundle between requesters and the scheduler
//   ena, req, lock, hold_len, data_in : into the scheduler
//   sel, grant, y, busy               : out of the scheduler
interface mux_rr_scheduler_if #(parameter int HOLD_W = 4);
    logic              ena;
    logic [3:0]        req;
    logic              lock;
    logic [HOLD_W-1:0] hold_len;
    logic [3:0]        data_in;
    logic [1:0]        sel;
    logic [3:0]        grant;
    logic              y;
    logic              busy;
    modport master (output ena, req, lock, hold_len, data_in, input sel, grant, y, busy);
    modport slave  (input ena, req, lock, hold_len, data_in, output sel, grant, y, busy);
endinterface

// File: rtl/mux_rr_scheduler_rr_pick4.sv
// rr_pick4: combinational round-robin pick of the first request at or after ptr
//   i_req[3:0] requests, i_ptr[1:0] highest-priority index
//   o_valid any request, o_idx chosen index, o_onehot chosen one-hot
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic       o_valid,
    output logic [1:0] o_idx,
    output logic [3:0] o_onehot
);
    logic [1:0] w_cand;
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_ptr;
        w_cand  = i_ptr;
        // scan from farthest to nearest so the nearest hit to ptr wins
        for (int k = 3; k >= 0; k--) begin
            w_cand = i_ptr + 2'(k);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
        o_onehot = o_valid ? 4'(1) << o_idx : 4'b0;
    end
endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin grant of the 4:1 mux select with hold length, lock and registered y
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of mux_rr_scheduler_if (ena/req/lock/hold_len/data_in in; sel/grant/y/busy out)
module mux_rr_scheduler
    import mux_rr_scheduler_pkg::*;
#(
    parameter int HOLD_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_rr_scheduler_if.slave   bus
);
    state_t             r_state, w_state;
    logic [HOLD_W-1:0]  r_cnt, w_cnt;
    logic [SEL_W-1:0]   r_ptr, w_ptr, r_sel, w_sel, w_idx;
    logic [NREQ-1:0]    r_grant, w_grant, w_onehot;
    logic               r_y, w_valid, w_release;

    rr_pick4 u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    // dropped request beats lock; otherwise expire only when unlocked at count 1
    assign w_release = !bus.req[r_sel] || (r_cnt == HOLD_W'(1) && !bus.lock);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ptr   = r_ptr;
        w_sel   = r_sel;
        w_grant = r_grant;
        case (r_state)
            IDLE: if (w_valid) begin
                w_state = GRANT;
                w_grant = w_onehot;
                w_sel   = w_idx;
                w_cnt   = (bus.hold_len == '0) ? HOLD_W'(1) : bus.hold_len;
            end
            GRANT: if (w_release) begin
                w_state = GAP;
                w_grant = '0;
                w_ptr   = r_sel + SEL_W'(1);
            end else begin
                w_cnt = (r_cnt > HOLD_W'(1)) ? r_cnt - HOLD_W'(1) : r_cnt;
            end
            default: begin
                w_state = IDLE;
                w_grant = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_grant <= '0;
            r_y     <= 1'b0;
        end else if (bus.ena) begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ptr   <= w_ptr;
            r_sel   <= w_sel;
            r_grant <= w_grant;
            r_y     <= (r_state == GRANT) ? bus.data_in[r_sel] : 1'b0;
        end
    end

    assign bus.sel   = r_sel;
    assign bus.grant = r_grant;
    assign bus.y     = r_y;
    assign bus.busy  = (r_state != IDLE);
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb_mux_rr_scheduler: directed self-checking bench for mux_rr_scheduler
module tb_mux_rr_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    mux_rr_scheduler_if #(.HOLD_W(4)) bus ();

    mux_rr_scheduler #(.HOLD_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.ena      = 1'b1;
        bus.req      = 4'b0000;
        bus.lock     = 1'b0;
        bus.hold_len = 4'd0;
        bus.data_in  = 4'b0000;
        #3;
        chk("rst_grant", 8'(bus.grant), 8'h0);
        chk("rst_sel",   8'(bus.sel),   8'h0);
        chk("rst_y",     8'(bus.y),     8'h0);
        chk("rst_busy",  8'(bus.busy),  8'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // grant requester 2, check y datapath and latency
        bus.req      = 4'b0100;
        bus.hold_len = 4'd5;
        tick();
        chk("g2_grant", 8'(bus.grant), 8'h4);
        chk("g2_sel",   8'(bus.sel),   8'h2);
        chk("g2_busy",  8'(bus.busy),  8'h1);
        chk("g2_y_lag", 8'(bus.y),     8'h0);
        bus.data_in = 4'b0100;
        tick();
        chk("y_d0100", 8'(bus.y), 8'h1);
        bus.data_in = 4'b1011;
        tick();
        chk("y_d1011", 8'(bus.y), 8'h0);
        bus.data_in = 4'b0100;
        tick();
        chk("y_d0100b", 8'(bus.y), 8'h1);
        chk("g2_held",  8'(bus.grant), 8'h4);

        // asynchronous reset mid-grant
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 8'(bus.grant), 8'h0);
        chk("arst_sel",   8'(bus.sel),   8'h0);
        chk("arst_y",     8'(bus.y),     8'h0);
        chk("arst_busy",  8'(bus.busy),  8'h0);
        rst_n        = 1'b1;
        bus.req      = 4'b1111;
        bus.hold_len = 4'd2;

        // rotation 0,1,2,3,0 with hold 2, gap, idle
        tick();
        chk("rot_first", 8'(bus.grant), 8'h1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("rot_hold", 8'(bus.grant), 8'(4'(1) << ((i - 1) % 4)));
            tick();
            chk("rot_gap_grant", 8'(bus.grant), 8'h0);
            chk("rot_gap_busy",  8'(bus.busy),  8'h1);
            tick();
            chk("rot_idle_busy", 8'(bus.busy),  8'h0);
            tick();
            chk("rot_grant", 8'(bus.grant), 8'(4'(1) << (i % 4)));
            chk("rot_sel",   8'(bus.sel),   8'(i % 4));
        end
        bus.req = 4'b0000;
        tick();
        chk("rot_drop", 8'(bus.grant), 8'h0);
        tick();

        // early release of requester 3 and pointer wrap to 0
        bus.req      = 4'b1000;
        bus.hold_len = 4'd5;
        tick();
        chk("er_grant", 8'(bus.grant), 8'h8);
        tick();
        chk("er_hold", 8'(bus.grant), 8'h8);
        bus.req = 4'b0000;
        tick();
        chk("er_release", 8'(bus.grant), 8'h0);
        chk("er_gap_busy", 8'(bus.busy), 8'h1);
        bus.req = 4'b1001;
        tick();
        chk("er_idle", 8'(bus.grant), 8'h0);
        tick();
        chk("er_wrap", 8'(bus.grant), 8'h1);
        chk("er_wrap_sel", 8'(bus.sel), 8'h0);
        bus.req = 4'b0000;
        tick();
        tick();

        // lock with hold_len 0 (treated as 1) held six cycles
        bus.req      = 4'b0010;
        bus.hold_len = 4'd0;
        bus.lock     = 1'b1;
        tick();
        chk("lk_grant", 8'(bus.grant), 8'h2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lk_hold", 8'(bus.grant), 8'h2);
        end
        bus.lock = 1'b0;
        tick();
        chk("lk_release", 8'(bus.grant), 8'h0);
        tick();

        // ena freeze shifts the release by three cycles
        bus.req      = 4'b0001;
        bus.hold_len = 4'd4;
        bus.data_in  = 4'b0001;
        tick();
        chk("en_grant", 8'(bus.grant), 8'h1);
        chk("en_y0",    8'(bus.y),     8'h0);
        tick();
        chk("en_y1", 8'(bus.y), 8'h1);
        bus.ena     = 1'b0;
        bus.data_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_frz_grant", 8'(bus.grant), 8'h1);
            chk("en_frz_y",     8'(bus.y),     8'h1);
        end
        bus.ena     = 1'b1;
        bus.data_in = 4'b0001;
        tick();
        chk("en_run_grant", 8'(bus.grant), 8'h1);
        chk("en_run_y",     8'(bus.y),     8'h1);
        tick();
        chk("en_last_grant", 8'(bus.grant), 8'h1);
        tick();
        chk("en_release", 8'(bus.grant), 8'h0);
        chk("en_gap_busy", 8'(bus.busy), 8'h1);
        tick();
        chk("en_y_after", 8'(bus.y),    8'h0);
        chk("en_idle",    8'(bus.busy), 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
